pipelined_carry_select_adder: RTL and testbench
===============================================

# pipelined_carry_select_adder

Parametrised, pipelined carry-select adder/subtractor: the next generation of the team's 16-bit combinational carry-select adder. Operands are split into BLOCK_W-bit blocks; each block precomputes sums for carry-in 0 and 1 and muxes on the incoming carry. Pipeline registers are inserted every BLOCKS_PER_STAGE blocks. A valid/ready handshake with backpressure lets the datapath feed wide ALU and accumulator paths at one result per cycle.

## Interface
Parameters:
- WIDTH, 32: operand and result width. Must be a multiple of BLOCK_W*BLOCKS_PER_STAGE.
- BLOCK_W, 4: bits per carry-select block. The lowest block is plain ripple.
- BLOCKS_PER_STAGE, 2: blocks evaluated per pipeline stage. Stage count S = WIDTH/(BLOCK_W*BLOCKS_PER_STAGE), so 4 with the defaults.

Ports:
- Clk  in  1  single clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- A  in  WIDTH  operand A.
- B  in  WIDTH  operand B.
- CI  in  1  carry-in. Ignored when Sub=1.
- Sub  in  1  1 selects A-B, computed as A + ~B + 1.
- in_valid  in  1  operands and control are valid.
- in_ready  out  1  block accepts the operands this cycle.
- Sum  out  WIDTH  result.
- CO  out  1  carry out of the MSB. On subtract this is the no-borrow flag (1 when A >= B unsigned).
- OV  out  1  two's-complement overflow.
- out_valid  out  1  Sum/CO/OV are valid.
- out_ready  in  1  consumer accepts the result.

## Operation
- Effective operand: Bx = Sub ? ~B : B. Effective carry-in: c0 = Sub ? 1 : CI.
- Stage k (k = 0..S-1) covers bits [(k+1)*SW-1 : k*SW], where SW = BLOCK_W*BLOCKS_PER_STAGE.
  - Its carry-in is c0 for k=0, otherwise the carry registered by stage k-1.
  - Inside a stage, each block j>0 computes sum0/cout0 (cin=0) and sum1/cout1 (cin=1).
  - Block j selects sum1 when its incoming carry is 1, otherwise sum0.
  - Carry into block j+1 = cout0 | (cin & cout1).
- Each stage register holds:
  - a valid bit;
  - the sum bits computed so far;
  - the stage carry-out;
  - the still-unprocessed upper bits of A and Bx (these are delayed, not recomputed);
  - the carry into bit WIDTH-1 once that bit has been processed.
- The final stage register drives the outputs directly.
  - Sum and CO come straight from it.
  - OV = carry into MSB XOR CO.
- Global advance: adv = !out_valid | out_ready.
  - in_ready = adv. This path is combinational, and it is the only combinational output path.
  - On adv, every stage register loads from its predecessor, valid bits included.
  - Rank 0 loads (in_valid & in_ready) together with the stage-0 result.
  - Bubbles propagate and are not collapsed.
  - When adv=0, all registers hold.
- Arithmetic is modulo 2^WIDTH. No saturation.

## Timing
- Reset (asynchronous, any cycle including mid-stream): all valid bits 0 and all data registers 0. Outputs become Sum=0, CO=0, OV=0, out_valid=0, and in_ready=1 immediately. In-flight transactions are discarded.
- Latency: a transfer accepted at edge N appears with out_valid=1 after edge N+S-1 (edge N+3 with defaults). With S=1 it appears after edge N.
- Throughput is one transaction per cycle while out_ready=1.
- Results hold stable while out_valid=1 and out_ready=0. in_ready stays 0 until the consumer accepts.
- Simultaneous output accept and input accept in the same cycle is legal and loses no data.
- Ordering is strictly FIFO.

## Configuration
- CSA_OVERFLOW_EN defined:
  - The MSB carry-in is tracked through the pipeline.
  - OV is computed as specified above.
- CSA_OVERFLOW_EN undefined:
  - The MSB carry-in register is not built.
  - OV is tied to 0.
  - Sum and CO are unaffected.

## Test plan
- Reset mid-stream: load 3 transactions, then pulse Reset. Required: out_valid=0, Sum=0, CO=0, OV=0 immediately, and none of the 3 results ever appear.
- Full carry ripple (defaults): A=32'hFFFF_FFFF, B=0, CI=1, Sub=0. Required: after 4 edges, Sum=0, CO=1, OV=0.
- Signed overflow: A=32'h7FFF_FFFF, B=1, Sub=0. Required: Sum=32'h8000_0000, CO=0, OV=1 (OV=0 when CSA_OVERFLOW_EN is undefined).
- Subtract: first A=5, B=7, Sub=1, CI=1 (CI must be ignored). Required: Sum=32'hFFFF_FFFE, CO=0, OV=0. Then A=7, B=5. Required: Sum=2, CO=1.
- Backpressure: stream 10 random transfers back-to-back with out_ready toggling randomly. Required: all 10 results match the reference model, in order, and in_ready==(!out_valid|out_ready) every cycle.
- Parameter sweep: (WIDTH, BLOCK_W, BLOCKS_PER_STAGE) = (16,4,4), (64,8,2), (24,4,1). Required: 1000 random vectors each bit-exact, with latency of 1, 4 and 6 edges respectively.

Source files
------------

// File: rtl/pipelined_carry_select_adder.sv
// Pipelined carry-select adder/subtractor with valid/ready flow control and one result per cycle.
// Optional feature macro CSA_OVERFLOW_EN: tracks the MSB carry-in and drives OV; undefined ties OV to 0.
module pipelined_carry_select_adder #(
  parameter int WIDTH            = 32,
  parameter int BLOCK_W          = 4,
  parameter int BLOCKS_PER_STAGE = 2
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CI,
  input  logic             Sub,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             CO,
  output logic             OV,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int SW = BLOCK_W * BLOCKS_PER_STAGE;
  localparam int S  = WIDTH / SW;
  localparam int NB = BLOCKS_PER_STAGE;

  logic             w_adv;
  logic [WIDTH-1:0] w_bx;
  logic             w_c0;

  assign w_bx     = Sub ? ~B : B;
  assign w_c0     = Sub ? 1'b1 : CI;
  assign w_adv    = !out_valid || out_ready;
  assign in_ready = w_adv;

  for (genvar k = 0; k < S; k++) begin : g_stage
    localparam int LO = k * SW;

    logic [SW-1:0]    w_a;
    logic [SW-1:0]    w_b;
    logic [SW-1:0]    w_s;
    logic             w_cin;
    logic             w_vin;
    logic [NB:1]      w_c;
    logic [LO+SW-1:0] w_sum_nxt;
    logic [BLOCK_W:0] w_r_lo;
    logic             r_valid;
    logic             r_carry;
    logic [LO+SW-1:0] r_sum;

    if (k == 0) begin : g_src
      assign w_a       = A[SW-1:0];
      assign w_b       = w_bx[SW-1:0];
      assign w_cin     = w_c0;
      assign w_vin     = in_valid && w_adv;
      assign w_sum_nxt = w_s;
    end else begin : g_src
      assign w_a       = g_stage[k-1].g_op.r_opa[SW-1:0];
      assign w_b       = g_stage[k-1].g_op.r_opb[SW-1:0];
      assign w_cin     = g_stage[k-1].r_carry;
      assign w_vin     = g_stage[k-1].r_valid;
      assign w_sum_nxt = {w_s, g_stage[k-1].r_sum};
    end

    // Lowest block of each stage ripples directly on the stage carry-in.
    assign w_r_lo = {1'b0, w_a[BLOCK_W-1:0]} + {1'b0, w_b[BLOCK_W-1:0]}
                  + {{BLOCK_W{1'b0}}, w_cin};
    assign w_s[BLOCK_W-1:0] = w_r_lo[BLOCK_W-1:0];
    assign w_c[1]           = w_r_lo[BLOCK_W];

    for (genvar j = 1; j < NB; j++) begin : g_blk
      logic [BLOCK_W:0] w_r0;
      logic [BLOCK_W:0] w_r1;

      assign w_r0 = {1'b0, w_a[j*BLOCK_W +: BLOCK_W]} + {1'b0, w_b[j*BLOCK_W +: BLOCK_W]};
      assign w_r1 = {1'b0, w_a[j*BLOCK_W +: BLOCK_W]} + {1'b0, w_b[j*BLOCK_W +: BLOCK_W]}
                  + {{BLOCK_W{1'b0}}, 1'b1};
      assign w_s[j*BLOCK_W +: BLOCK_W] = w_c[j] ? w_r1[BLOCK_W-1:0] : w_r0[BLOCK_W-1:0];
      assign w_c[j+1] = w_r0[BLOCK_W] | (w_c[j] & w_r1[BLOCK_W]);
    end

    always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
        r_valid <= 1'b0;
        r_carry <= 1'b0;
        r_sum   <= '0;
      end else if (w_adv) begin
        r_valid <= w_vin;
        r_carry <= w_c[NB];
        r_sum   <= w_sum_nxt;
      end
    end

    // Upper operand bits are only delayed until the stage that consumes them.
    if (k < S - 1) begin : g_op
      localparam int REM = WIDTH - LO - SW;

      logic [REM-1:0] w_opa_nxt;
      logic [REM-1:0] w_opb_nxt;
      logic [REM-1:0] r_opa;
      logic [REM-1:0] r_opb;

      if (k == 0) begin : g_ld
        assign w_opa_nxt = A[WIDTH-1:SW];
        assign w_opb_nxt = w_bx[WIDTH-1:SW];
      end else begin : g_ld
        assign w_opa_nxt = g_stage[k-1].g_op.r_opa[WIDTH-LO-1:SW];
        assign w_opb_nxt = g_stage[k-1].g_op.r_opb[WIDTH-LO-1:SW];
      end

      always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
          r_opa <= '0;
          r_opb <= '0;
        end else if (w_adv) begin
          r_opa <= w_opa_nxt;
          r_opb <= w_opb_nxt;
        end
      end
    end

`ifdef CSA_OVERFLOW_EN
    if (k == S - 1) begin : g_ovf
      logic r_msbc;

      // Carry into the MSB recovered from its sum bit and operand bits.
      always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
          r_msbc <= 1'b0;
        end else if (w_adv) begin
          r_msbc <= w_s[SW-1] ^ w_a[SW-1] ^ w_b[SW-1];
        end
      end
    end
`endif
  end

  assign Sum       = g_stage[S-1].r_sum;
  assign CO        = g_stage[S-1].r_carry;
  assign out_valid = g_stage[S-1].r_valid;

`ifdef CSA_OVERFLOW_EN
  assign OV = g_stage[S-1].g_ovf.r_msbc ^ g_stage[S-1].r_carry;
`else
  assign OV = 1'b0;
`endif

endmodule

// File: tb/tb_pipelined_carry_select_adder.sv
// Self-checking bench: default 32-bit instance for directed/backpressure/reset tests,
// plus three parameter-sweep instances fed with shared random vectors.
module tb_pipelined_carry_select_adder;

`ifdef CSA_OVERFLOW_EN
  localparam bit OVF = 1'b1;
`else
  localparam bit OVF = 1'b0;
`endif

  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  int n_cmp = 0;
  int n_err = 0;

  // default instance
  logic [31:0] d_a, d_b, d_sum;
  logic        d_ci, d_sub, d_iv, d_ir, d_co, d_ov, d_ovld, d_or;

  // sweep instances share inputs
  logic [63:0] s_a, s_b;
  logic        s_ci, s_sub, s_iv, s_or;
  logic [15:0] x16_sum;
  logic [63:0] x64_sum;
  logic [23:0] x24_sum;
  logic        x16_co, x16_ov, x16_ovld, x16_ir;
  logic        x64_co, x64_ov, x64_ovld, x64_ir;
  logic        x24_co, x24_ov, x24_ovld, x24_ir;

  pipelined_carry_select_adder u_dut (
    .Clk(Clk), .Reset(Reset), .A(d_a), .B(d_b), .CI(d_ci), .Sub(d_sub),
    .in_valid(d_iv), .in_ready(d_ir), .Sum(d_sum), .CO(d_co), .OV(d_ov),
    .out_valid(d_ovld), .out_ready(d_or));

  pipelined_carry_select_adder #(.WIDTH(16), .BLOCK_W(4), .BLOCKS_PER_STAGE(4)) u_x16 (
    .Clk(Clk), .Reset(Reset), .A(s_a[15:0]), .B(s_b[15:0]), .CI(s_ci), .Sub(s_sub),
    .in_valid(s_iv), .in_ready(x16_ir), .Sum(x16_sum), .CO(x16_co), .OV(x16_ov),
    .out_valid(x16_ovld), .out_ready(s_or));

  pipelined_carry_select_adder #(.WIDTH(64), .BLOCK_W(8), .BLOCKS_PER_STAGE(2)) u_x64 (
    .Clk(Clk), .Reset(Reset), .A(s_a), .B(s_b), .CI(s_ci), .Sub(s_sub),
    .in_valid(s_iv), .in_ready(x64_ir), .Sum(x64_sum), .CO(x64_co), .OV(x64_ov),
    .out_valid(x64_ovld), .out_ready(s_or));

  pipelined_carry_select_adder #(.WIDTH(24), .BLOCK_W(4), .BLOCKS_PER_STAGE(1)) u_x24 (
    .Clk(Clk), .Reset(Reset), .A(s_a[23:0]), .B(s_b[23:0]), .CI(s_ci), .Sub(s_sub),
    .in_valid(s_iv), .in_ready(x24_ir), .Sum(x24_sum), .CO(x24_co), .OV(x24_ov),
    .out_valid(x24_ovld), .out_ready(s_or));

  // Reference: unsigned arithmetic for Sum/CO, sign rules for overflow.
  function automatic void ref_model(input int w, input logic [63:0] a_in, input logic [63:0] b_in,
                                    input logic ci, input logic sub,
                                    output logic [63:0] s, output logic co, output logic ov);
    logic [63:0] mask, a, b;
    logic [64:0] t;
    logic        sa, sb, ss;
    mask = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    a = a_in & mask;
    b = b_in & mask;
    if (sub) begin
      t  = {1'b0, a} - {1'b0, b};
      co = (a >= b);
    end else begin
      t  = {1'b0, a} + {1'b0, b} + {64'd0, ci};
      co = t[w];
    end
    s  = t[63:0] & mask;
    sa = a[w-1];
    sb = b[w-1];
    ss = s[w-1];
    ov = sub ? ((sa != sb) && (ss != sa)) : ((sa == sb) && (ss != sa));
    ov = ov & OVF;
  endfunction

  task automatic send_one(input logic [31:0] a, input logic [31:0] b, input logic ci, input logic sub,
                          output logic early_v, output logic v, output logic [31:0] s,
                          output logic co, output logic ov);
    @(negedge Clk);
    d_a = a; d_b = b; d_ci = ci; d_sub = sub; d_iv = 1'b1; d_or = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    d_iv = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    early_v = d_ovld;
    @(negedge Clk);
    v = d_ovld; s = d_sum; co = d_co; ov = d_ov;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    d_a = 32'd0; d_b = 32'd0; d_ci = 1'b0; d_sub = 1'b0; d_iv = 1'b0; d_or = 1'b1;
    s_a = 64'd0; s_b = 64'd0; s_ci = 1'b0; s_sub = 1'b0; s_iv = 1'b0; s_or = 1'b1;
    #1;
    n_cmp++;
    if (d_ovld !== 1'b0 || d_sum !== 32'd0 || d_co !== 1'b0 || d_ov !== 1'b0 || d_ir !== 1'b1) begin
      n_err++;
      $display("FAIL reset_state: got v=%b sum=%h co=%b ov=%b rdy=%b, want v=0 sum=0 co=0 ov=0 rdy=1",
               d_ovld, d_sum, d_co, d_ov, d_ir);
    end
    @(negedge Clk);
    Reset = 1'b0;
  endtask

  task automatic test_directed();
    logic [31:0] ta[5], tb[5], ts[5];
    logic        tci[5], tsub[5], tco[5], tov[5];
    logic        ev, v, co, ov;
    logic [31:0] s;
    ta[0] = 32'hFFFF_FFFF; tb[0] = 32'd0; tci[0] = 1'b1; tsub[0] = 1'b0; ts[0] = 32'd0;         tco[0] = 1'b1; tov[0] = 1'b0;
    ta[1] = 32'h7FFF_FFFF; tb[1] = 32'd1; tci[1] = 1'b0; tsub[1] = 1'b0; ts[1] = 32'h8000_0000; tco[1] = 1'b0; tov[1] = OVF;
    ta[2] = 32'd5;         tb[2] = 32'd7; tci[2] = 1'b1; tsub[2] = 1'b1; ts[2] = 32'hFFFF_FFFE; tco[2] = 1'b0; tov[2] = 1'b0;
    ta[3] = 32'd7;         tb[3] = 32'd5; tci[3] = 1'b1; tsub[3] = 1'b1; ts[3] = 32'd2;         tco[3] = 1'b1; tov[3] = 1'b0;
    ta[4] = 32'h8000_0000; tb[4] = 32'd1; tci[4] = 1'b0; tsub[4] = 1'b1; ts[4] = 32'h7FFF_FFFF; tco[4] = 1'b1; tov[4] = OVF;
    for (int i = 0; i < 5; i++) begin
      send_one(ta[i], tb[i], tci[i], tsub[i], ev, v, s, co, ov);
      n_cmp++;
      if (ev !== 1'b0 || v !== 1'b1) begin
        n_err++;
        $display("FAIL directed_latency[%0d]: got valid@N+2=%b valid@N+3=%b, want 0 and 1", i, ev, v);
      end
      n_cmp++;
      if (s !== ts[i] || co !== tco[i] || ov !== tov[i]) begin
        n_err++;
        $display("FAIL directed_result[%0d]: got sum=%h co=%b ov=%b, want sum=%h co=%b ov=%b",
                 i, s, co, ov, ts[i], tco[i], tov[i]);
      end
    end
  endtask

  task automatic test_reset_midstream();
    d_or = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      d_a = $urandom | 32'h0001_0001; d_b = $urandom; d_ci = 1'b1; d_sub = 1'b0; d_iv = 1'b1;
      @(posedge Clk);
    end
    #2 Reset = 1'b1;
    #1;
    n_cmp++;
    if (d_ovld !== 1'b0 || d_sum !== 32'd0 || d_co !== 1'b0 || d_ov !== 1'b0 || d_ir !== 1'b1) begin
      n_err++;
      $display("FAIL midstream_reset: got v=%b sum=%h co=%b ov=%b rdy=%b, want v=0 sum=0 co=0 ov=0 rdy=1",
               d_ovld, d_sum, d_co, d_ov, d_ir);
    end
    @(negedge Clk);
    Reset = 1'b0;
    d_iv  = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge Clk);
      n_cmp++;
      if (d_ovld !== 1'b0) begin
        n_err++;
        $display("FAIL midstream_ghost: cycle %0d got out_valid=%b, want 0", i, d_ovld);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] q_s[$];
    logic        q_co[$], q_ov[$];
    logic [63:0] es;
    logic        eco, eov, hold;
    logic [31:0] h_sum, xs;
    logic        h_co, h_ov, xco, xov;
    int          sent, got;
    sent = 0; got = 0; hold = 1'b0;
    h_sum = 32'd0; h_co = 1'b0; h_ov = 1'b0;
    for (int cyc = 0; cyc < 400 && got < 10; cyc++) begin
      @(negedge Clk);
      if (hold) begin
        n_cmp++;
        if (d_ovld !== 1'b1 || d_sum !== h_sum || d_co !== h_co || d_ov !== h_ov) begin
          n_err++;
          $display("FAIL bp_hold: got v=%b sum=%h co=%b ov=%b, want v=1 sum=%h co=%b ov=%b",
                   d_ovld, d_sum, d_co, d_ov, h_sum, h_co, h_ov);
        end
      end
      d_or = 1'($urandom_range(0, 1));
      if (sent < 10) begin
        d_iv = 1'b1; d_a = $urandom; d_b = $urandom;
        d_ci = 1'($urandom_range(0, 1)); d_sub = 1'($urandom_range(0, 1));
      end else begin
        d_iv = 1'b0;
      end
      #1;
      n_cmp++;
      if (d_ir !== (!d_ovld | d_or)) begin
        n_err++;
        $display("FAIL bp_in_ready: got %b, want %b (out_valid=%b out_ready=%b)", d_ir, !d_ovld | d_or, d_ovld, d_or);
      end
      if (d_ovld === 1'b1 && d_or) begin
        n_cmp++;
        if (q_s.size() == 0) begin
          n_err++;
          $display("FAIL bp_unexpected: got sum=%h with no result outstanding, want nothing", d_sum);
        end else begin
          xs = q_s.pop_front(); xco = q_co.pop_front(); xov = q_ov.pop_front();
          if (d_sum !== xs || d_co !== xco || d_ov !== xov) begin
            n_err++;
            $display("FAIL bp_result[%0d]: got sum=%h co=%b ov=%b, want sum=%h co=%b ov=%b",
                     got, d_sum, d_co, d_ov, xs, xco, xov);
          end
        end
        got++;
      end
      if (d_iv && d_ir === 1'b1) begin
        ref_model(32, {32'd0, d_a}, {32'd0, d_b}, d_ci, d_sub, es, eco, eov);
        q_s.push_back(es[31:0]); q_co.push_back(eco); q_ov.push_back(eov);
        sent++;
      end
      hold = (d_ovld === 1'b1) && !d_or;
      h_sum = d_sum; h_co = d_co; h_ov = d_ov;
    end
    n_cmp++;
    if (got != 10) begin
      n_err++;
      $display("FAIL bp_timeout: got %0d results, want 10", got);
    end
    d_iv = 1'b0;
    d_or = 1'b1;
    repeat (6) @(negedge Clk);
  endtask

  task automatic test_param_sweep();
    logic [63:0] v_a[1000], v_b[1000];
    logic        v_ci[1000], v_sub[1000];
    logic [63:0] o_s, e_s;
    logic        o_v, o_co, o_ov, o_ir, e_co, e_ov, exp_v;
    int          w, lat, idx;
    for (int i = 0; i < 1000; i++) begin
      v_a[i] = {$urandom, $urandom}; v_b[i] = {$urandom, $urandom};
      v_ci[i] = 1'($urandom_range(0, 1)); v_sub[i] = 1'($urandom_range(0, 1));
    end
    v_a[0] = {64{1'b1}}; v_b[0] = 64'd0; v_ci[0] = 1'b1; v_sub[0] = 1'b0;
    s_or = 1'b1;
    for (int c = 0; c <= 1006; c++) begin
      @(negedge Clk);
      for (int i = 0; i < 3; i++) begin
        case (i)
          0: begin w = 16; lat = 1; o_v = x16_ovld; o_s = {48'd0, x16_sum}; o_co = x16_co; o_ov = x16_ov; o_ir = x16_ir; end
          1: begin w = 64; lat = 4; o_v = x64_ovld; o_s = x64_sum;          o_co = x64_co; o_ov = x64_ov; o_ir = x64_ir; end
          default: begin w = 24; lat = 6; o_v = x24_ovld; o_s = {40'd0, x24_sum}; o_co = x24_co; o_ov = x24_ov; o_ir = x24_ir; end
        endcase
        idx   = c - lat;
        exp_v = (idx >= 0) && (idx < 1000);
        n_cmp++;
        if (o_v !== exp_v || o_ir !== 1'b1) begin
          n_err++;
          $display("FAIL sweep_valid w=%0d cycle=%0d: got v=%b rdy=%b, want v=%b rdy=1", w, c, o_v, o_ir, exp_v);
        end
        if (exp_v) begin
          ref_model(w, v_a[idx], v_b[idx], v_ci[idx], v_sub[idx], e_s, e_co, e_ov);
          n_cmp++;
          if (o_s !== e_s || o_co !== e_co || o_ov !== e_ov) begin
            n_err++;
            $display("FAIL sweep_result w=%0d vec=%0d: got sum=%h co=%b ov=%b, want sum=%h co=%b ov=%b",
                     w, idx, o_s, o_co, o_ov, e_s, e_co, e_ov);
          end
        end
      end
      if (c < 1000) begin
        s_iv = 1'b1; s_a = v_a[c]; s_b = v_b[c]; s_ci = v_ci[c]; s_sub = v_sub[c];
      end else begin
        s_iv = 1'b0;
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_reset_midstream();
    test_backpressure();
    test_param_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
